// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor controller.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             busy;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a_in, b_in, ack,
    input  ready, busy, valid, diff, bout
  );

  modport slave (
    input  start, a_in, b_in, ack,
    output ready, busy, valid, diff, bout
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor step per cycle, LSB first,
// result held with valid until acknowledged.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             ready_q, busy_q, valid_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             ready_nxt, busy_nxt, valid_nxt;

  logic             d_c, br_c, last_c;
  logic [WIDTH-1:0] r_nxt_c;

  // Two cascaded half-subtractors plus borrow OR on the current LSBs
  always_comb begin
    d_c     = a_sh[0] ^ b_sh[0] ^ br;
    br_c    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    r_nxt_c = (r_sh >> 1) | (WIDTH'(d_c) << (WIDTH - 1));
    last_c  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_c)    state_nxt = DONE;
      DONE:    if (bus.ack)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they register in step with it
  always_comb begin
    ready_nxt = 1'b0;
    busy_nxt  = 1'b0;
    valid_nxt = 1'b0;
    case (state_nxt)
      IDLE:    ready_nxt = 1'b1;
      RUN:     busy_nxt  = 1'b1;
      DONE:    valid_nxt = 1'b1;
      default: ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
    end
  end

  // Operand/result shift registers; diff/bout only change on the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a_in;
            b_sh <= bus.b_in;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt_c;
          br   <= br_c;
          cnt  <= cnt + CW'(1);
          if (last_c) begin
            diff_q <= r_nxt_c;
            bout_q <= br_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH=1, 8 and 16,
// all three instances driven from one shared stimulus.
module tb_serial_subtractor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ack;
  logic [15:0] a, b;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(1))  i1 ();
  serial_subtractor_ctrl_if #(.WIDTH(8))  i8 ();
  serial_subtractor_ctrl_if #(.WIDTH(16)) i16 ();

  assign i1.start  = start;  assign i1.ack  = ack;
  assign i1.a_in   = a[0];   assign i1.b_in = b[0];
  assign i8.start  = start;  assign i8.ack  = ack;
  assign i8.a_in   = a[7:0]; assign i8.b_in = b[7:0];
  assign i16.start = start;  assign i16.ack = ack;
  assign i16.a_in  = a;      assign i16.b_in = b;

  serial_subtractor_ctrl #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(i1.slave));
  serial_subtractor_ctrl #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_subtractor_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_all_valid();
    int n = 0;
    while (!(i1.valid && i8.valid && i16.valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("valid_timeout", 64'(n), 64'(0));
  endtask

  task automatic ack_all();
    wait_all_valid();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs [4] = '{
    '{8'h3C, 8'h5A, 8'hE2, 1'b1},
    '{8'h00, 8'h01, 8'hFF, 1'b1},
    '{8'hFF, 8'hFF, 8'h00, 1'b0},
    '{8'h80, 8'h7F, 8'h01, 1'b0}
  };

  initial begin
    int          nb, n, rdy_seen, vcnt;
    logic [7:0]  held_d;
    logic        held_bo;
    logic [1:0]  r1;
    logic [8:0]  r8;
    logic [16:0] r16;

    rst = 1'b1; start = 1'b0; ack = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(i8.ready), 64'(1));
    check("rst_busy",  64'(i8.busy),  64'(0));
    check("rst_valid", 64'(i8.valid), 64'(0));
    check("rst_diff",  64'(i8.diff),  64'(0));
    check("rst_bout",  64'(i8.bout),  64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic operation and latency
    launch(16'h005A, 16'h003C);
    nb = 0; n = 0;
    while (!i8.valid && n < 50) begin
      if (i8.busy) nb++;
      @(negedge clk);
      n++;
    end
    check("t1_busy_cycles", 64'(nb), 64'(8));
    check("t1_diff",  64'(i8.diff),  64'(8'h1E));
    check("t1_bout",  64'(i8.bout),  64'(0));
    check("t1_ready_in_done", 64'(i8.ready), 64'(0));
    check("t1_busy_in_done",  64'(i8.busy),  64'(0));
    ack_all();
    check("t1_ready_after_ack", 64'(i8.ready), 64'(1));
    check("t1_valid_after_ack", 64'(i8.valid), 64'(0));

    foreach (vecs[i]) begin
      launch(16'(vecs[i].a), 16'(vecs[i].b));
      wait_all_valid();
      check($sformatf("t2_diff_%0d", i), 64'(i8.diff), 64'(vecs[i].d));
      check($sformatf("t2_bout_%0d", i), 64'(i8.bout), 64'(vecs[i].bo));
      ack_all();
    end

    // START held and operands changed after acceptance
    a = 16'h0011; b = 16'h0022; start = 1'b1;
    @(negedge clk);
    rdy_seen = 0; vcnt = 0; n = 0;
    while (!(i1.valid && i8.valid && i16.valid) && n < 100) begin
      a = a + 16'h0105; b = b ^ 16'h00F3;
      if (i8.ready) rdy_seen++;
      @(negedge clk);
      n++;
    end
    repeat (2) begin
      if (i8.ready) rdy_seen++;
      if (i8.valid) vcnt++;
      @(negedge clk);
    end
    check("t3_ready_seen", 64'(rdy_seen), 64'(0));
    check("t3_valid_held", 64'(vcnt), 64'(2));
    check("t3_diff", 64'(i8.diff), 64'(8'hEF));
    check("t3_bout", 64'(i8.bout), 64'(1));
    start = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("t3_valid_drop", 64'(i8.valid), 64'(0));
    check("t3_ready_back", 64'(i8.ready), 64'(1));
    vcnt = 0;
    repeat (12) begin
      if (i8.valid) vcnt++;
      @(negedge clk);
    end
    check("t3_no_second_result", 64'(vcnt), 64'(0));

    // Delayed ACK: result must hold steady
    launch(16'h00A0, 16'h000F);
    wait_all_valid();
    held_d = i8.diff; held_bo = i8.bout;
    check("t4_diff", 64'(held_d), 64'(8'h91));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_valid_%0d", k), 64'(i8.valid), 64'(1));
      check($sformatf("t4_diff_%0d", k),  64'(i8.diff),  64'(8'h91));
      check($sformatf("t4_bout_%0d", k),  64'(i8.bout),  64'(0));
      @(negedge clk);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("t4_valid_drop", 64'(i8.valid), 64'(0));

    // Reset during the third RUN cycle
    launch(16'h0077, 16'h0011);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready", 64'(i8.ready), 64'(1));
    check("t5_busy",  64'(i8.busy),  64'(0));
    check("t5_valid", 64'(i8.valid), 64'(0));
    check("t5_diff",  64'(i8.diff),  64'(0));
    check("t5_bout",  64'(i8.bout),  64'(0));
    rst = 1'b0;
    vcnt = 0;
    repeat (20) begin
      if (i1.valid || i8.valid || i16.valid) vcnt++;
      @(negedge clk);
    end
    check("t5_no_valid", 64'(vcnt), 64'(0));

    // Random pairs against an arithmetic reference at all three widths
    for (int i = 0; i < 1000; i++) begin
      launch(16'($urandom), 16'($urandom));
      wait_all_valid();
      r1  = {1'b0, a[0]}    - {1'b0, b[0]};
      r8  = {1'b0, a[7:0]}  - {1'b0, b[7:0]};
      r16 = {1'b0, a}       - {1'b0, b};
      check("t6_w1",  64'({i1.bout,  i1.diff}),  64'(r1));
      check("t6_w8",  64'({i8.bout,  i8.diff}),  64'(r8));
      check("t6_w16", 64'({i16.bout, i16.diff}), 64'(r16));
      ack_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
